tetron_collision_checker: RTL
=============================

Name: tetron_collision_checker

Overview:
- Sits directly downstream of the per-tetromino shapers.
- Takes the active piece's anchor position plus the four signed block offsets (voffset/hoffset pairs) and decides whether that placement collides with the field walls, the floor, or an occupied cell.
- Reads the playfield occupancy RAM through a one-cycle-latency read port, one cell per cycle, pipelined, with early abort.
- The game controller uses the result to accept or reject each move, rotate or drop.

Parameters:
- FIELD_W, 10, playfield columns (0 = left).
- FIELD_H, 20, playfield rows (0 = top; rows grow downward).
- COORD_W, 5, width of anchor coordinates and offsets; offsets are two's complement.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- check_req  in  1  start pulse; sampled only in IDLE
- piece_row  in  COORD_W  anchor row, unsigned
- piece_col  in  COORD_W  anchor column, unsigned
- blk1_voffset..blk4_voffset  in  COORD_W each  signed row offsets
- blk1_hoffset..blk4_hoffset  in  COORD_W each  signed column offsets
- field_rd_en  out  1  playfield read strobe
- field_rd_row  out  COORD_W  read row address
- field_rd_col  out  COORD_W  read column address
- field_rd_data  in  1  occupancy of the addressed cell; valid exactly one cycle after field_rd_en
- busy  out  1  high from the cycle after acceptance until done
- done  out  1  one-cycle result pulse
- collision  out  1  result; held until the next acceptance
- cause_oob  out  1  a block fell outside the field; held
- cause_occ  out  1  a block hit an occupied cell; held

Behaviour:
- Reset (async): FSM to IDLE; all outputs 0; internal snapshot cleared. Reset mid-check aborts the check with no done pulse.
- Acceptance: in IDLE with check_req=1 at cycle T:
  - Snapshot piece_row, piece_col and all 8 offsets.
  - Clear collision and both cause flags.
  - Enter PROBE; busy=1 from T+1.
  - check_req outside IDLE is ignored. Inputs may change after T.
- Cell arithmetic, per block k:
  - Row = zero-extended anchor + sign-extended offset, computed in COORD_W+1 bits signed. Column is computed the same way.
  - The cell is out of bounds if row<0, row>=FIELD_H, col<0 or col>=FIELD_W.
- PROBE, cycles T+1..T+4, block k=1..4 at T+k:
  - In-bounds block: field_rd_en=1, address = computed row/col.
  - Out-of-bounds block: field_rd_en=0 and an OOB hit is flagged that cycle.
- Evaluation:
  - field_rd_data for block k is evaluated at T+k+1.
  - A 1 flags an occupied hit.
  - Data returned for a read issued before an abort is ignored.
- Early abort: on the first cycle any hit is flagged, go to DONE.
  - No further reads are issued.
  - If OOB and occupied hits are flagged in the same cycle, both cause bits are set.
- Full pass: if no hit is flagged through the evaluation at T+5, go to DONE at T+5.
- DONE, one cycle:
  - done=1, busy=0.
  - collision = cause_oob | cause_occ.
  - Then IDLE. A check_req in the cycle done is high is not accepted.
- Latency:
  - No collision: done at T+6.
  - Block k OOB: done at T+k+1.
  - Block k occupied: done at T+k+2.
- Duplicate offsets are legal; the cell is simply read twice.
- field_rd_row/col hold their last value when field_rd_en=0.

Optional Feature:
- Macro: COLL_ALLOW_ABOVE_TOP_EN.
- Defined: row<0 with an in-range column counts as free (spawn/rotation above the visible field). No read is issued and no hit is flagged.
- Undefined: row<0 is an OOB hit as above.

Decomposition:
- Shared package tetris_pkg holds:
  - FIELD_W, FIELD_H, COORD_W.
  - The FSM state typedef (IDLE, PROBE, DONE).
  - A cause encoding typedef shared with the controller.
- One natural sub-module, tetron_cell_resolver: purely combinational anchor+offset adder and bounds compare, producing row, col, oob. Instantiate it once on the muxed block index.

Test Plan:
- Anchor (5,4), offsets (0,0),(-1,-1),(0,-1),(1,0), empty field -> reads at T+1..T+4 of (5,4),(4,3),(5,3),(6,4); done at T+6; collision=0.
- Same piece, cell (5,3) occupied -> reads stop after block 3; done at T+5; collision=1, cause_occ=1, cause_oob=0.
- Anchor (19,4) with block 4 offset (1,0) -> block 4 OOB at T+4, no read that cycle; done at T+5; cause_oob=1.
- Anchor (0,0) with block 2 offset (-1,-1) -> OOB at T+2; done at T+3. Repeat with COLL_ALLOW_ABOVE_TOP_EN: the row<0 check passes, but col -1 is still OOB. Then offset (-1,0): no collision, done at T+6.
- check_req held high continuously -> each check accepted only from IDLE; consecutive done pulses 7 cycles apart on a clean field.
- rst asserted at T+3 -> outputs 0 immediately, no done; the next check_req runs a clean check.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared playfield geometry, checker FSM states and the collision cause encoding
// used by the collision checker and the game controller.
package tetris_pkg;

  localparam int FIELD_W = 10;
  localparam int FIELD_H = 20;
  localparam int COORD_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROBE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_OOB  = 2'b01,
    CAUSE_OCC  = 2'b10,
    CAUSE_BOTH = 2'b11
  } cause_t;

  function automatic cause_t cause_encode(input logic oob, input logic occ);
    return cause_t'({occ, oob});
  endfunction

endpackage

// File: rtl/tetron_cell_resolver.sv
// Combinational anchor+offset adder and field bounds compare for one block.
// COLL_ALLOW_ABOVE_TOP_EN: rows above the top with a legal column are free.
module tetron_cell_resolver
  import tetris_pkg::*;
(
  input  logic [COORD_W-1:0] anchor_row,
  input  logic [COORD_W-1:0] anchor_col,
  input  logic [COORD_W-1:0] voffset,
  input  logic [COORD_W-1:0] hoffset,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               oob,
  output logic               above_top
);

  logic [COORD_W:0] row_sum;
  logic [COORD_W:0] col_sum;
  logic             row_neg;
  logic             row_high;
  logic             col_bad;

  // Sums are two's complement in COORD_W+1 bits; the top bit is the sign.
  assign row_sum  = {1'b0, anchor_row} + {voffset[COORD_W-1], voffset};
  assign col_sum  = {1'b0, anchor_col} + {hoffset[COORD_W-1], hoffset};

  assign row_neg  = row_sum[COORD_W];
  assign row_high = !row_sum[COORD_W] && (row_sum[COORD_W-1:0] >= COORD_W'(FIELD_H));
  assign col_bad  = col_sum[COORD_W] || (col_sum[COORD_W-1:0] >= COORD_W'(FIELD_W));

  assign row = row_sum[COORD_W-1:0];
  assign col = col_sum[COORD_W-1:0];

`ifdef COLL_ALLOW_ABOVE_TOP_EN
  assign above_top = row_neg && !col_bad;
  assign oob       = row_high || col_bad;
`else
  assign above_top = 1'b0;
  assign oob       = row_neg || row_high || col_bad;
`endif

endmodule

// File: rtl/tetron_collision_checker.sv
// Checks a tetromino placement against walls, floor and occupied cells, probing
// one block per cycle with early abort. Honours COLL_ALLOW_ABOVE_TOP_EN via the resolver.
module tetron_collision_checker
  import tetris_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               check_req,
  input  logic [COORD_W-1:0] piece_row,
  input  logic [COORD_W-1:0] piece_col,
  input  logic [COORD_W-1:0] blk1_voffset,
  input  logic [COORD_W-1:0] blk2_voffset,
  input  logic [COORD_W-1:0] blk3_voffset,
  input  logic [COORD_W-1:0] blk4_voffset,
  input  logic [COORD_W-1:0] blk1_hoffset,
  input  logic [COORD_W-1:0] blk2_hoffset,
  input  logic [COORD_W-1:0] blk3_hoffset,
  input  logic [COORD_W-1:0] blk4_hoffset,
  output logic               field_rd_en,
  output logic [COORD_W-1:0] field_rd_row,
  output logic [COORD_W-1:0] field_rd_col,
  input  logic               field_rd_data,
  output logic               busy,
  output logic               done,
  output logic               collision,
  output logic               cause_oob,
  output logic               cause_occ
);

  // Handshake: check_req is taken only in IDLE; busy covers the probe, done pulses
  // once with collision/cause flags, which then hold until the next acceptance.
  state_t             state;
  logic [2:0]         idx;
  logic [COORD_W-1:0] snap_row;
  logic [COORD_W-1:0] snap_col;
  logic [COORD_W-1:0] snap_voff [4];
  logic [COORD_W-1:0] snap_hoff [4];
  logic               rd_pending;
  logic [COORD_W-1:0] last_row;
  logic [COORD_W-1:0] last_col;

  logic [1:0]         sel;
  logic               blk_active;
  logic [COORD_W-1:0] cell_row;
  logic [COORD_W-1:0] cell_col;
  logic               cell_oob;
  logic               cell_above;
  logic               oob_now;
  logic               occ_now;
  logic               hit;
  logic               rd_en_c;

  // idx 1..4 probes block idx; idx 5 only evaluates block 4's read data.
  assign sel        = 2'(idx[1:0] - 2'd1);
  assign blk_active = (state == ST_PROBE) && (idx != 3'd5);

  tetron_cell_resolver u_resolver (
    .anchor_row (snap_row),
    .anchor_col (snap_col),
    .voffset    (snap_voff[sel]),
    .hoffset    (snap_hoff[sel]),
    .row        (cell_row),
    .col        (cell_col),
    .oob        (cell_oob),
    .above_top  (cell_above)
  );

  assign oob_now = blk_active && cell_oob;
  assign occ_now = rd_pending && field_rd_data;
  assign hit     = oob_now || occ_now;
  assign rd_en_c = blk_active && !cell_oob && !cell_above && !occ_now;

  assign field_rd_en  = rd_en_c;
  assign field_rd_row = rd_en_c ? cell_row : last_row;
  assign field_rd_col = rd_en_c ? cell_col : last_col;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= 3'd0;
      snap_row   <= '0;
      snap_col   <= '0;
      for (int i = 0; i < 4; i++) begin
        snap_voff[i] <= '0;
        snap_hoff[i] <= '0;
      end
      rd_pending <= 1'b0;
      last_row   <= '0;
      last_col   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      collision  <= 1'b0;
      cause_oob  <= 1'b0;
      cause_occ  <= 1'b0;
    end else begin
      if (rd_en_c) begin
        last_row <= cell_row;
        last_col <= cell_col;
      end
      case (state)
        ST_IDLE: begin
          rd_pending <= 1'b0;
          if (check_req) begin
            snap_row     <= piece_row;
            snap_col     <= piece_col;
            snap_voff[0] <= blk1_voffset;
            snap_voff[1] <= blk2_voffset;
            snap_voff[2] <= blk3_voffset;
            snap_voff[3] <= blk4_voffset;
            snap_hoff[0] <= blk1_hoffset;
            snap_hoff[1] <= blk2_hoffset;
            snap_hoff[2] <= blk3_hoffset;
            snap_hoff[3] <= blk4_hoffset;
            idx          <= 3'd1;
            collision    <= 1'b0;
            cause_oob    <= 1'b0;
            cause_occ    <= 1'b0;
            busy         <= 1'b1;
            state        <= ST_PROBE;
          end
        end
        ST_PROBE: begin
          rd_pending <= rd_en_c;
          if (hit) begin
            cause_oob  <= oob_now;
            cause_occ  <= occ_now;
            collision  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b1;
            rd_pending <= 1'b0;
            state      <= ST_DONE;
          end else if (idx == 3'd5) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        ST_DONE: begin
          done       <= 1'b0;
          rd_pending <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
